// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: retire-stage commit trace capture into a circular buffer with a valid/ready drain port
module commit_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_valid,
  input  logic [DATA_W-1:0]            commit_pc,
  input  logic                         commit_regwrite,
  input  logic [REG_W-1:0]             commit_wreg,
  input  logic [DATA_W-1:0]            commit_wdata,
  input  logic                         commit_memread,
  input  logic                         commit_memwrite,
  input  logic [DATA_W-1:0]            commit_addr,
  input  logic [DATA_W-1:0]            commit_mdata,
  input  logic                         commit_halt,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [4*DATA_W+REG_W+3:0]    rd_rec,
  output logic [CNT_W-1:0]             rd_inum,
  output logic [CNT_W-1:0]             rd_cycle,
  output logic [ADDR_W:0]              occupancy,
  output logic                         overflow,
  output logic                         halted,
  output logic                         done
);
  localparam int REC_W = 4*DATA_W+REG_W+4;
  typedef enum logic [1:0] {RUN, DRAIN, FIN} state_e;
  state_e                       state_q;
  logic [ADDR_W-1:0]            wr_q, rd_q;
  logic [ADDR_W:0]              occ_q, occ_d;
  logic [CNT_W-1:0]             inst_q, cycle_q;
  logic                         ovf_q, halted_q, done_q;
  logic                         run, pop, push, full;
  logic [REC_W+2*CNT_W-1:0]     mem [DEPTH];
  always_comb begin
    run   = state_q == RUN;
    pop   = rd_valid & rd_ready;
    full  = occ_q == (ADDR_W+1)'(DEPTH);
    push  = run & commit_valid & (~full | pop);
    occ_d = occ_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end
  always_ff @(posedge clk)
    if (push)
      mem[wr_q] <= {commit_halt, commit_memwrite, commit_memread, commit_regwrite, commit_wreg,
                    commit_pc, commit_wdata, commit_addr, commit_mdata, inst_q, cycle_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      inst_q   <= '0;
      cycle_q  <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_q    <= wr_q + ADDR_W'(push);
      rd_q    <= rd_q + ADDR_W'(pop);
      occ_q   <= occ_d;
      inst_q  <= inst_q + CNT_W'(run & commit_valid);
      cycle_q <= cycle_q + CNT_W'(run);
      ovf_q   <= ovf_q | (run & commit_valid & full & ~pop);
      // a dropped halt still closes capture; DRAIN finishes once the last pop lands
      case (state_q)
        RUN: if (commit_valid & commit_halt) begin
          state_q  <= DRAIN;
          halted_q <= 1'b1;
        end
        DRAIN: if (occ_d == '0) begin
          state_q <= FIN;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign {rd_rec, rd_inum, rd_cycle} = mem[rd_q];
  assign rd_valid  = occ_q != '0;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;
  assign halted    = halted_q;
  assign done      = done_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: vector table plus queue-based reference model for commit_trace_buffer
module tb_commit_trace_buffer;
  localparam int DEPTH = 4, AW = 2, DW = 16, RW = 3, CW = 4, REC_W = 4*DW+RW+4;
  logic clk = 1'b0, rst;
  logic cv, rw, mr, mw, halt, rdy;
  logic [DW-1:0] pc, wdata, addr, mdata;
  logic [RW-1:0] wreg;
  logic rd_valid, overflow, halted, done;
  logic [REC_W-1:0] rd_rec;
  logic [CW-1:0] rd_inum, rd_cycle;
  logic [AW:0] occupancy;
  always #5 clk = ~clk;
  commit_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .commit_valid(cv), .commit_pc(pc), .commit_regwrite(rw),
    .commit_wreg(wreg), .commit_wdata(wdata), .commit_memread(mr), .commit_memwrite(mw),
    .commit_addr(addr), .commit_mdata(mdata), .commit_halt(halt), .rd_ready(rdy),
    .rd_valid(rd_valid), .rd_rec(rd_rec), .rd_inum(rd_inum), .rd_cycle(rd_cycle),
    .occupancy(occupancy), .overflow(overflow), .halted(halted), .done(done));
  typedef struct {
    logic cv, rw, mr, mw, halt, rdy;
    logic [DW-1:0] pc, wdata, addr, mdata;
    logic [RW-1:0] wreg;
  } in_t;
  typedef struct {logic [REC_W-1:0] rec; int inum; int cyc;} exp_t;
  typedef struct {logic cv; logic [DW-1:0] pc; logic rdy; logic ev; int eocc; int einum;} vec_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_inst, m_cyc, m_st;
  bit m_ovf;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic in_t mk(input logic c, input logic [DW-1:0] p, input logic r);
    in_t i;
    i.cv = c; i.pc = p; i.rdy = r; i.rw = c; i.wreg = RW'(p[3:1] + 3'd1);
    i.wdata = p ^ 16'h5a5a; i.mr = 1'b0; i.mw = 1'b0; i.addr = '0; i.mdata = '0; i.halt = 1'b0;
    return i;
  endfunction
  function automatic logic [REC_W-1:0] mkrec(input in_t i);
    return {i.halt, i.mw, i.mr, i.rw, i.wreg, i.pc, i.wdata, i.addr, i.mdata};
  endfunction
  task automatic drive(input in_t i);
    cv = i.cv; pc = i.pc; rw = i.rw; wreg = i.wreg; wdata = i.wdata; mr = i.mr;
    mw = i.mw; addr = i.addr; mdata = i.mdata; halt = i.halt; rdy = i.rdy;
  endtask
  task automatic cyc(input in_t i);
    exp_t e;
    drive(i);
    chk("rd_valid", 128'(rd_valid), 128'(q.size() != 0));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("halted", 128'(halted), 128'(m_st != 0));
    chk("done", 128'(done), 128'(m_st == 2));
    chk("inst_count", 128'(dut.inst_q), 128'(m_inst));
    chk("cycle_count", 128'(dut.cycle_q), 128'(m_cyc));
    if (q.size() != 0) begin
      chk("rd_rec", 128'(rd_rec), 128'(q[0].rec));
      chk("rd_inum", 128'(rd_inum), 128'(q[0].inum));
      chk("rd_cycle", 128'(rd_cycle), 128'(q[0].cyc));
      if (i.rdy) void'(q.pop_front());
    end
    if (m_st == 0) begin
      if (i.cv) begin
        if (q.size() < DEPTH) begin
          e.rec = mkrec(i); e.inum = m_inst; e.cyc = m_cyc;
          q.push_back(e);
        end else m_ovf = 1'b1;
        m_inst = (m_inst + 1) % 16;
        if (i.halt) m_st = 1;
      end
      m_cyc = (m_cyc + 1) % 16;
    end else if (m_st == 1 && q.size() == 0) m_st = 2;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    drive(mk(1'b0, '0, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_inst = 0; m_cyc = 0; m_st = 0; m_ovf = 1'b0;
  endtask
  initial begin
    vec_t tv[8];
    in_t s, h;
    tv[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 0, 0};
    tv[1] = '{1'b1, 16'h0002, 1'b0, 1'b1, 1, 0};
    tv[2] = '{1'b1, 16'h0004, 1'b0, 1'b1, 2, 0};
    tv[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 0};
    tv[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2, 1};
    tv[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 2};
    tv[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 0};
    tv[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      chk("tv_occ", 128'(occupancy), 128'(tv[k].eocc));
      chk("tv_valid", 128'(rd_valid), 128'(tv[k].ev));
      if (tv[k].ev) chk("tv_inum", 128'(rd_inum), 128'(tv[k].einum));
      cyc(mk(tv[k].cv, tv[k].pc, tv[k].rdy));
    end
    // overflow: six commits into four entries
    do_reset();
    for (int k = 0; k < 6; k++) cyc(mk(1'b1, 16'(2*k), 1'b0));
    chk("ovf_occ", 128'(occupancy), 128'(4));
    chk("ovf_flag", 128'(overflow), 128'(1));
    chk("ovf_inst", 128'(dut.inst_q), 128'(6));
    for (int k = 0; k < 4; k++) cyc(mk(1'b0, '0, 1'b1));
    chk("ovf_empty", 128'(occupancy), 128'(0));
    cyc(mk(1'b1, 16'h0040, 1'b0));
    chk("ovf_next_inum", 128'(rd_inum), 128'(6));
    cyc(mk(1'b0, '0, 1'b1));
    // full with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 4; k++) cyc(mk(1'b1, 16'(2*k), 1'b0));
    for (int k = 4; k < 9; k++) cyc(mk(1'b1, 16'(2*k), 1'b1));
    chk("pp_ovf", 128'(overflow), 128'(0));
    chk("pp_occ", 128'(occupancy), 128'(4));
    for (int k = 0; k < 4; k++) cyc(mk(1'b0, '0, 1'b1));
    // store, halt, trailing commits ignored, drain to done
    do_reset();
    s = mk(1'b1, 16'h0004, 1'b0); s.rw = 1'b0; s.mw = 1'b1; s.addr = 16'h0010; s.mdata = 16'hBEEF;
    h = mk(1'b1, 16'h0006, 1'b0); h.rw = 1'b0; h.halt = 1'b1;
    cyc(s);
    chk("pre_halt", 128'(halted), 128'(0));
    cyc(h);
    chk("halted_next", 128'(halted), 128'(1));
    cyc(mk(1'b1, 16'h0008, 1'b0));
    cyc(mk(1'b1, 16'h000a, 1'b0));
    chk("halt_inst", 128'(dut.inst_q), 128'(2));
    chk("halt_occ", 128'(occupancy), 128'(2));
    cyc(mk(1'b0, '0, 1'b1));
    chk("not_done", 128'(done), 128'(0));
    chk("halt_bit", 128'(rd_rec[REC_W-1]), 128'(1));
    cyc(mk(1'b0, '0, 1'b1));
    chk("done", 128'(done), 128'(1));
    cyc(mk(1'b1, 16'h000c, 1'b1));
    // reset while draining
    do_reset();
    h.pc = 16'h0004;
    cyc(mk(1'b1, 16'h0000, 1'b0));
    cyc(mk(1'b1, 16'h0002, 1'b0));
    cyc(h);
    cyc(mk(1'b0, '0, 1'b0));
    chk("drain_occ", 128'(occupancy), 128'(3));
    do_reset();
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(rd_valid), 128'(0));
    chk("rst_cycle", 128'(dut.cycle_q), 128'(0));
    cyc(mk(1'b1, 16'h0100, 1'b0));
    chk("fresh_inum", 128'(rd_inum), 128'(0));
    cyc(mk(1'b0, '0, 1'b1));
    // counter wrap with a 4-bit instruction counter
    do_reset();
    for (int k = 0; k < 17; k++) cyc(mk(1'b1, 16'(2*k), 1'b1));
    chk("wrap_inst", 128'(dut.inst_q), 128'(1));
    chk("wrap_inum", 128'(rd_inum), 128'(0));
    cyc(mk(1'b0, '0, 1'b1));
    cyc(mk(1'b0, '0, 1'b0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
